// File: rtl/cordic_iter_ctrl_if.sv
// Bundle of job-request, ALU-stage and result signals around the CORDIC sequencer.
// The controller takes the slave view; the surrounding system takes the master view.
interface cordic_iter_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [15:0] in_target;

   logic [15:0] alu_x_init;
   logic [15:0] alu_y_init;
   logic [15:0] alu_x_shift;
   logic [15:0] alu_y_shift;
   logic [15:0] alu_angle;
   logic [15:0] alu_delta_angle;
   logic [15:0] alu_target_angle;
   logic [3:0]  alu_select;
   logic [15:0] alu_x_out;
   logic [15:0] alu_y_out;
   logic [15:0] alu_angle_out;

   logic        out_valid;
   logic        out_ready;
   logic [15:0] x_res;
   logic [15:0] y_res;
   logic [15:0] z_res;

   modport slave (
      input  in_valid, in_mode, in_x, in_y, in_target,
      input  alu_x_out, alu_y_out, alu_angle_out, out_ready,
      output in_ready, alu_x_init, alu_y_init, alu_x_shift, alu_y_shift,
      output alu_angle, alu_delta_angle, alu_target_angle, alu_select,
      output out_valid, x_res, y_res, z_res
   );

   modport master (
      output in_valid, in_mode, in_x, in_y, in_target,
      output alu_x_out, alu_y_out, alu_angle_out, out_ready,
      input  in_ready, alu_x_init, alu_y_init, alu_x_shift, alu_y_shift,
      input  alu_angle, alu_delta_angle, alu_target_angle, alu_select,
      input  out_valid, x_res, y_res, z_res
   );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: feeds an external single-step x/y/angle stage for ITER
// micro-rotations per job and returns final x, y and the residual angle.
module cordic_iter_ctrl #(
   parameter int               WIDTH = 16,
   parameter int               ITER  = 16,
   parameter logic [WIDTH-1:0] BIAS  = 16'h4000
) (
   input logic              clk,
   input logic              rst_n,
   cordic_iter_ctrl_if.slave ctrl
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // atan(2^-i) in units of 2^16 per turn
   localparam logic [WIDTH-1:0] ATAN_LUT [16] = '{
      16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
      16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000
   };
   localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, angle_q, angle_d, target_q, target_d;
   logic [WIDTH-1:0] delta_q, delta_d;
   logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
   logic             mode_q, mode_d;
   logic [3:0]       iter_q, iter_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         angle_q  <= '0;
         target_q <= '0;
         delta_q  <= '0;
         xr_q     <= '0;
         yr_q     <= '0;
         zr_q     <= '0;
         mode_q   <= 1'b0;
         iter_q   <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         angle_q  <= angle_d;
         target_q <= target_d;
         delta_q  <= delta_d;
         xr_q     <= xr_d;
         yr_q     <= yr_d;
         zr_q     <= zr_d;
         mode_q   <= mode_d;
         iter_q   <= iter_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      angle_d  = angle_q;
      target_d = target_q;
      delta_d  = delta_q;
      xr_d     = xr_q;
      yr_d     = yr_q;
      zr_d     = zr_q;
      mode_d   = mode_q;
      iter_d   = iter_q;
      case (state_q)
         IDLE: begin
            if (ctrl.in_valid) begin
               x_d      = ctrl.in_x;
               y_d      = ctrl.in_y;
               angle_d  = BIAS;
               target_d = ctrl.in_target + BIAS;
               mode_d   = ctrl.in_mode;
               iter_d   = '0;
               delta_d  = ATAN_LUT[0];
               state_d  = RUN;
            end
         end
         RUN: begin
            x_d     = ctrl.alu_x_out;
            y_d     = ctrl.alu_y_out;
            angle_d = ctrl.alu_angle_out;
            iter_d  = iter_q + 4'd1;
            if (iter_q == LAST_ITER) begin
               // Capture results from the final step so they stay stable in DONE
               xr_d    = ctrl.alu_x_out;
               yr_d    = ctrl.alu_y_out;
               zr_d    = ctrl.alu_angle_out - (mode_q ? BIAS : target_q);
               state_d = DONE;
            end else begin
               delta_d = ATAN_LUT[iter_q + 4'd1];
            end
         end
         DONE: begin
            if (ctrl.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ctrl.in_ready         = (state_q == IDLE);
   assign ctrl.out_valid        = (state_q == DONE);
   assign ctrl.alu_x_init       = x_q;
   assign ctrl.alu_y_init       = y_q;
   assign ctrl.alu_x_shift      = WIDTH'($signed(x_q) >>> iter_q);
   assign ctrl.alu_y_shift      = WIDTH'($signed(y_q) >>> iter_q);
   assign ctrl.alu_angle        = angle_q;
   assign ctrl.alu_delta_angle  = delta_q;
   assign ctrl.alu_target_angle = target_q;
   assign ctrl.alu_select       = {mode_q, 3'b000};
   assign ctrl.x_res            = xr_q;
   assign ctrl.y_res            = yr_q;
   assign ctrl.z_res            = zr_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for the CORDIC sequencer with a behavioural add/sub stage model;
// covers rotation, vectoring, backpressure, mid-run reset and a single-iteration build.
module tb_cordic_iter_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] min_ang;

   always #5 clk = ~clk;

   cordic_iter_ctrl_if dut_if ();
   cordic_iter_ctrl_if one_if ();

   cordic_iter_ctrl #(.WIDTH(16), .ITER(16), .BIAS(16'h4000)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl(dut_if.slave)
   );
   cordic_iter_ctrl #(.WIDTH(16), .ITER(1), .BIAS(16'h4000)) dut_one (
      .clk(clk), .rst_n(rst_n), .ctrl(one_if.slave)
   );

   // One micro-rotation: counter-clockwise when below target (rotation) or y<0 (vectoring)
   function automatic logic [47:0] alu_model(input logic [15:0] x, y, a, t, xs, ys, d,
                                             input logic [3:0] sel);
      logic ccw;
      ccw = sel[3] ? y[15] : (a < t);
      if (ccw) return {x - ys, y + xs, a + d};
      else     return {x + ys, y - xs, a - d};
   endfunction

   assign {dut_if.alu_x_out, dut_if.alu_y_out, dut_if.alu_angle_out} =
      alu_model(dut_if.alu_x_init, dut_if.alu_y_init, dut_if.alu_angle, dut_if.alu_target_angle,
                dut_if.alu_x_shift, dut_if.alu_y_shift, dut_if.alu_delta_angle, dut_if.alu_select);
   assign {one_if.alu_x_out, one_if.alu_y_out, one_if.alu_angle_out} =
      alu_model(one_if.alu_x_init, one_if.alu_y_init, one_if.alu_angle, one_if.alu_target_angle,
                one_if.alu_x_shift, one_if.alu_y_shift, one_if.alu_delta_angle, one_if.alu_select);

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      checks++;
      if (obs > exp + tol || obs < exp - tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Launch a job on the ITER=16 unit; xs1/ys1 are the hand-computed shifts at i=1
   task automatic run_job(input string name, input logic mode, input logic [15:0] x, y, t,
                          input logic [15:0] xs1, ys1);
      int n;
      logic [15:0] tgt_b;
      tgt_b = t + 16'h4000;
      @(negedge clk);
      dut_if.in_valid  = 1'b1;
      dut_if.in_mode   = mode;
      dut_if.in_x      = x;
      dut_if.in_y      = y;
      dut_if.in_target = t;
      @(posedge clk); #1;
      dut_if.in_valid = 1'b0;
      check({name, "_busy"},   int'(dut_if.in_ready), 0);
      check({name, "_xinit"},  int'(dut_if.alu_x_init), int'(x));
      check({name, "_yinit"},  int'(dut_if.alu_y_init), int'(y));
      check({name, "_ang0"},   int'(dut_if.alu_angle), 16'h4000);
      check({name, "_tgt"},    int'(dut_if.alu_target_angle), int'(tgt_b));
      check({name, "_delta0"}, int'(dut_if.alu_delta_angle), 16'h2000);
      check({name, "_sel"},    int'(dut_if.alu_select), mode ? 8 : 0);
      min_ang = dut_if.alu_angle;
      n = 0;
      while (!dut_if.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            check({name, "_xs1"},    int'(dut_if.alu_x_shift), int'(xs1));
            check({name, "_ys1"},    int'(dut_if.alu_y_shift), int'(ys1));
            check({name, "_delta1"}, int'(dut_if.alu_delta_angle), 16'h12E4);
         end
         if (!dut_if.out_valid && dut_if.alu_angle < min_ang) min_ang = dut_if.alu_angle;
      end
      check({name, "_latency"}, n, 16);
      $display("job %s mode=%0d x_res=%0d y_res=%0d z_res=%0d latency=%0d", name, mode,
               $signed(dut_if.x_res), $signed(dut_if.y_res), $signed(dut_if.z_res), n);
   endtask

   task automatic finish_job(input string name);
      @(negedge clk);
      dut_if.out_ready = 1'b1;
      @(posedge clk); #1;
      dut_if.out_ready = 1'b0;
      check({name, "_ovalid_clr"}, int'(dut_if.out_valid), 0);
      check({name, "_idle"},       int'(dut_if.in_ready), 1);
   endtask

   initial begin
      dut_if.in_valid = 1'b0; dut_if.in_mode = 1'b0; dut_if.out_ready = 1'b0;
      dut_if.in_x = '0; dut_if.in_y = '0; dut_if.in_target = '0;
      one_if.in_valid = 1'b0; one_if.in_mode = 1'b0; one_if.out_ready = 1'b0;
      one_if.in_x = '0; one_if.in_y = '0; one_if.in_target = '0;

      #12;
      check("rst_ovalid", int'(dut_if.out_valid), 0);
      check("rst_xres",   int'(dut_if.x_res), 0);
      check("rst_zres",   int'(dut_if.z_res), 0);
      check("rst_delta",  int'(dut_if.alu_delta_angle), 0);
      check("rst_angle",  int'(dut_if.alu_angle), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_inready", int'(dut_if.in_ready), 1);

      // Rotate (0x4000,0) by 45 deg
      run_job("rot45", 1'b0, 16'h4000, 16'h0000, 16'h2000, 16'h2000, 16'h2000);
      check("rot45_x", $signed(dut_if.x_res), 19078, 8);
      check("rot45_y", $signed(dut_if.y_res), 19078, 8);
      check("rot45_z", $signed(dut_if.z_res), 0, 4);
      finish_job("rot45");

      // Rotate by 0: first step goes clockwise, biased angle must stay >= 0x2000
      run_job("rot0", 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'hE000);
      check("rot0_x", $signed(dut_if.x_res), 26981, 8);
      check("rot0_y", $signed(dut_if.y_res), 0, 8);
      check("rot0_angle_floor", int'(min_ang >= 16'h2000), 1);
      finish_job("rot0");

      // Vectoring of (0x3000,0x3000), followed by held backpressure
      run_job("vec", 1'b1, 16'h3000, 16'h3000, 16'h0000, 16'h3000, 16'h0000);
      check("vec_x", $signed(dut_if.x_res), 28618, 8);
      check("vec_y", $signed(dut_if.y_res), 0, 8);
      check("vec_z", $signed(dut_if.z_res), -8192, 4);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         dut_if.in_valid = k[0];
         dut_if.in_x     = 16'h1234;
         dut_if.in_mode  = 1'b0;
         @(posedge clk); #1;
         check("bp_ovalid", int'(dut_if.out_valid), 1);
         check("bp_inready", int'(dut_if.in_ready), 0);
         check("bp_x", $signed(dut_if.x_res), 28618, 8);
         check("bp_z", $signed(dut_if.z_res), -8192, 4);
      end
      // in_valid asserted together with the output handshake must not start a job
      @(negedge clk);
      dut_if.in_valid  = 1'b1;
      dut_if.out_ready = 1'b1;
      @(posedge clk); #1;
      dut_if.in_valid  = 1'b0;
      dut_if.out_ready = 1'b0;
      check("hs_ovalid", int'(dut_if.out_valid), 0);
      check("hs_noaccept", int'(dut_if.in_ready), 1);
      @(posedge clk); #1;
      check("hs_still_idle", int'(dut_if.in_ready), 1);

      // Asynchronous reset at i=7
      @(negedge clk);
      dut_if.in_valid  = 1'b1;
      dut_if.in_mode   = 1'b0;
      dut_if.in_x      = 16'h4000;
      dut_if.in_y      = 16'h0000;
      dut_if.in_target = 16'h2000;
      @(posedge clk); #1;
      dut_if.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_xinit",  int'(dut_if.alu_x_init), 0);
      check("mrst_angle",  int'(dut_if.alu_angle), 0);
      check("mrst_tgt",    int'(dut_if.alu_target_angle), 0);
      check("mrst_delta",  int'(dut_if.alu_delta_angle), 0);
      check("mrst_ovalid", int'(dut_if.out_valid), 0);
      check("mrst_idle",   int'(dut_if.in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_job("rerun", 1'b0, 16'h4000, 16'h0000, 16'h2000, 16'h2000, 16'h2000);
      check("rerun_x", $signed(dut_if.x_res), 19078, 8);
      check("rerun_y", $signed(dut_if.y_res), 19078, 8);
      check("rerun_z", $signed(dut_if.z_res), 0, 4);
      finish_job("rerun");

      // Single-iteration build: one step of 45 deg from (0x4000,0)
      @(negedge clk);
      one_if.in_valid  = 1'b1;
      one_if.in_mode   = 1'b0;
      one_if.in_x      = 16'h4000;
      one_if.in_y      = 16'h0000;
      one_if.in_target = 16'h2000;
      @(posedge clk); #1;
      one_if.in_valid = 1'b0;
      check("one_run_ovalid", int'(one_if.out_valid), 0);
      @(posedge clk); #1;
      check("one_ovalid", int'(one_if.out_valid), 1);
      check("one_x", int'(one_if.x_res), 16'h4000);
      check("one_y", int'(one_if.y_res), 16'h4000);
      check("one_z", int'(one_if.z_res), 0);
      $display("job one mode=0 x_res=%0d y_res=%0d z_res=%0d", $signed(one_if.x_res),
               $signed(one_if.y_res), $signed(one_if.z_res));
      @(negedge clk);
      one_if.out_ready = 1'b1;
      @(posedge clk); #1;
      one_if.out_ready = 1'b0;
      check("one_idle", int'(one_if.in_ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Iterative CORDIC sequencer that wraps the single-step add/sub ALU stage (x/y/angle ALU top). It holds the x, y and angle working registers and drives the stage's operands each cycle: shifted copies, the arctan table entry and the mode select. It registers the stage's results and counts iterations. It accepts one job through a valid/ready handshake and returns the final x, y and residual angle through an output valid/ready handshake.

Parameters:
WIDTH, 16, data and angle width (fixed at 16 to match the ALU stage)
ITER, 16, number of micro-rotations per job; legal range 1..16
BIAS, 16'h4000, angle offset applied internally so unsigned angle compares never wrap

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job request
in_ready  out  1  high only in IDLE
in_mode  in  1  0 = rotation, 1 = vectoring
in_x  in  16  signed initial x
in_y  in  16  signed initial y
in_target  in  16  target angle, 2^16 = 360 deg, legal 0x0000..0x4000; ignored in vectoring
alu_x_init  out  16  x working register
alu_y_init  out  16  y working register
alu_x_shift  out  16  x_reg >>> i (arithmetic)
alu_y_shift  out  16  y_reg >>> i (arithmetic)
alu_angle  out  16  angle working register (biased)
alu_delta_angle  out  16  atan LUT[i]
alu_target_angle  out  16  in_target + BIAS, latched
alu_select  out  4  {mode, 3'b000}
alu_x_out  in  16  stage x result (combinational)
alu_y_out  in  16  stage y result
alu_angle_out  in  16  stage angle result
out_valid  out  1  result available, held until accepted
out_ready  in  1  consumer accept
x_res  out  16  final x (CORDIC gain K≈1.6468 not compensated)
y_res  out  16  final y
z_res  out  16  signed residual: angle_reg − alu_target_angle in rotation; angle_reg − BIAS in vectoring

Behaviour:
- Reset (async, any state): state=IDLE, all registers and outputs 0, out_valid=0, in_ready=1 after release.
- States are IDLE, RUN and DONE.
- IDLE: in_ready=1. When in_valid=1 at a clock edge, latch x/y, angle=BIAS, target+BIAS, mode, i=0, and go to RUN.
- RUN: each cycle load x/y/angle from alu_*_out and increment i. After the update with i=ITER−1, go to DONE. The job takes exactly ITER cycles in RUN.
- DONE: out_valid=1 with x_res/y_res/z_res stable. When out_ready=1 at an edge, go to IDLE.
- A new job cannot be accepted in the same cycle as the output handshake. Minimum job spacing is ITER+2 cycles.
- in_valid outside IDLE is ignored. The latched job is unaffected.
- Latency: accept edge at T0 gives out_valid high after edge T0+ITER.
- LUT values (atan(2^-i)·65536/360, rounded), i=0..15: 0x2000, 0x12E4, 0x09FB, 0x0511, 0x028B, 0x0146, 0x00A3, 0x0051, 0x0029, 0x0014, 0x000A, 0x0005, 0x0003, 0x0001, 0x0001, 0x0000.
- Shifts use sign extension. At i=0 the shift is the operand itself.
- Input magnitude: sqrt(x²+y²) ≤ 0x4000. Outside this range, wrap on overflow is permitted and not checked.
- Vectoring mode drives y toward 0. z_res ≈ −atan2(y,x) in angle units.
- ALU operand outputs are registered values. They are held constant outside RUN.

Test Plan:
- Rotation: x=0x4000, y=0, target=0x2000, ITER=16 -> after 16 RUN cycles out_valid=1; x_res≈y_res≈19078 ±8; z_res within ±4 of 0.
- Rotation, target 0: x=0x4000, y=0, target=0 -> x_res≈26981 ±8, y_res within ±8 of 0, angle never wraps (monitor alu_angle ≥ 0x2000).
- Vectoring: mode=1, x=0x3000, y=0x3000 -> x_res≈28618 ±8, y_res within ±8 of 0, z_res≈0xE000 ±4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and results stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE the next cycle.
- Reset mid-run: assert rst_n=0 asynchronously at i=7 -> outputs 0 and state IDLE immediately; new job after release completes with correct results.
- ITER=1 build: x=0x4000, y=0, target=0x2000 -> single step, out_valid one cycle after accept; x_res=0x4000, y_res=0x4000, z_res=0.
